// File: rtl/jpeg_rle_pkg.sv
// Shared types for the JPEG run-length encoder: FSM states, special symbol
// constants and the held-symbol record.
package jpeg_rle_pkg;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        EMIT_ZRL = 2'd1,
        EMIT_SYM = 2'd2,
        EMIT_EOB = 2'd3
    } rle_state_t;

    localparam logic [3:0] ZRL_RUN  = 4'd15;
    localparam int         ZRL_SIZE = 0;
    localparam logic [3:0] EOB_RUN  = 4'd0;
    localparam int         EOB_SIZE = 0;

    // Symbol fields are sized for the widest supported coefficient (16 bits).
    localparam int SYM_SIZE_W = 5;
    localparam int SYM_AMP_W  = 16;

    typedef struct packed {
        logic [3:0]            run;
        logic [SYM_SIZE_W-1:0] size;
        logic [SYM_AMP_W-1:0]  amp;
        logic                  eob;
    } rle_sym_t;

endpackage

// File: rtl/jpeg_size_cat.sv
// Combinational magnitude category and JPEG amplitude bits for one signed
// coefficient.
module jpeg_size_cat #(
    parameter int COEF_W = 12,
    parameter int SIZE_W = 4
) (
    input  logic [COEF_W-1:0] coef,
    output logic [SIZE_W-1:0] size,
    output logic [COEF_W-1:0] amp
);

    logic [COEF_W-1:0] mag;
    logic [COEF_W-1:0] coef_m1;
    logic [COEF_W-1:0] mask;

    always_comb begin
        // Unsigned magnitude: the most-negative value maps to 2^(COEF_W-1).
        mag     = coef[COEF_W-1] ? (~coef + COEF_W'(1)) : coef;
        coef_m1 = coef - COEF_W'(1);
        size    = '0;
        for (int i = 0; i < COEF_W; i++) begin
            if (mag[i]) size = SIZE_W'(i + 1);
        end
        mask = '0;
        for (int i = 0; i < COEF_W; i++) begin
            if (i < int'(size)) mask[i] = 1'b1;
        end
        amp = coef[COEF_W-1] ? (coef_m1 & mask) : coef;
    end

endmodule

// File: rtl/jpeg_rle_encoder.sv
// JPEG zigzag run-length encoder: turns a block of quantised coefficients into
// (run, size, amp) symbols with ZRL and EOB insertion behind a one-entry slot.
module jpeg_rle_encoder
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W  = 12,
    parameter int BLK_LEN = 64,
    parameter int SIZE_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_coef,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_run,
    output logic [SIZE_W-1:0] out_size,
    output logic [COEF_W-1:0] out_amp,
    output logic              out_eob,
    output logic              err_len,
    output logic [1:0]        dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // a producer keeps its payload stable while valid is high and ready low.

    localparam int IDX_W = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_LEN - 1);

    localparam rle_sym_t ZRL_SYM = '{run: ZRL_RUN, size: SYM_SIZE_W'(ZRL_SIZE),
                                     amp: '0, eob: 1'b0};
    localparam rle_sym_t EOB_SYM = '{run: EOB_RUN, size: SYM_SIZE_W'(EOB_SIZE),
                                     amp: '0, eob: 1'b1};

    rle_state_t        state, state_n;
    logic [IDX_W-1:0]  idx, run, zrl_cnt, zrl_need;
    rle_sym_t          held, cur_sym, load_sym;
    logic [SIZE_W-1:0] cat_size;
    logic [COEF_W-1:0] cat_amp;
    logic              take, slot_free, is_last, is_dc, coef_nz;
    logic              load, zrl_load, zrl_dec, held_load;

    jpeg_size_cat #(
        .COEF_W(COEF_W),
        .SIZE_W(SIZE_W)
    ) u_size_cat (
        .coef(in_coef),
        .size(cat_size),
        .amp (cat_amp)
    );

    assign slot_free = !out_valid || out_ready;
    assign take      = in_valid && in_ready;
    assign is_last   = (idx == LAST_IDX);
    assign is_dc     = (idx == '0);
    assign coef_nz   = |in_coef;
    assign zrl_need  = run >> 4;
    assign dbg_state = state;

    // Run is always zero at DC, so the DC symbol reuses the AC symbol format.
    always_comb begin
        cur_sym = '{run: 4'(run), size: SYM_SIZE_W'(cat_size),
                    amp: SYM_AMP_W'(cat_amp), eob: 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        load      = 1'b0;
        load_sym  = '0;
        zrl_load  = 1'b0;
        zrl_dec   = 1'b0;
        held_load = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = slot_free && !rst;
                if (take) begin
                    if (is_dc) begin
                        load     = 1'b1;
                        load_sym = cur_sym;
                    end else if (coef_nz) begin
                        if (zrl_need != '0) begin
                            zrl_load  = 1'b1;
                            held_load = 1'b1;
                            state_n   = EMIT_ZRL;
                        end else begin
                            load     = 1'b1;
                            load_sym = cur_sym;
                            if (is_last) state_n = EMIT_SYM;
                        end
                    end else if (is_last) begin
                        // Trailing zeros collapse into one EOB; pending ZRLs are dropped.
                        load     = 1'b1;
                        load_sym = EOB_SYM;
                        state_n  = EMIT_EOB;
                    end
                end
            end
            EMIT_ZRL: begin
                if (slot_free) begin
                    load = 1'b1;
                    if (zrl_cnt != '0) begin
                        load_sym = ZRL_SYM;
                        zrl_dec  = 1'b1;
                    end else begin
                        load_sym = held;
                        state_n  = EMIT_SYM;
                    end
                end
            end
            EMIT_SYM, EMIT_EOB: begin
                if (out_valid && out_ready) state_n = COLLECT;
            end
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            run       <= '0;
            zrl_cnt   <= '0;
            held      <= '0;
            err_len   <= 1'b0;
            out_valid <= 1'b0;
            out_run   <= '0;
            out_size  <= '0;
            out_amp   <= '0;
            out_eob   <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_run   <= load_sym.run;
                out_size  <= SIZE_W'(load_sym.size);
                out_amp   <= COEF_W'(load_sym.amp);
                out_eob   <= load_sym.eob;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (take) begin
                // The internal count, not in_last, defines the block boundary.
                idx <= is_last ? '0 : idx + IDX_W'(1);
                if (is_dc || coef_nz || is_last) run <= '0;
                else                             run <= run + IDX_W'(1);
                if (in_last != is_last) err_len <= 1'b1;
            end

            if (zrl_load)     zrl_cnt <= zrl_need;
            else if (zrl_dec) zrl_cnt <= zrl_cnt - IDX_W'(1);

            if (held_load) held <= cur_sym;
        end
    end

endmodule

// File: doc/jpeg_rle_encoder.md
JPEG_RLE_ENCODER -- requirements
Module: jpeg_rle_encoder

Interface
REQ-001 Parameter COEF_W, default 12: signed quantised-coefficient width.
REQ-002 Parameter BLK_LEN, default 64: coefficients per block; legal range 2..1024.
REQ-003 Parameter SIZE_W, default 4: width of magnitude category; SHALL hold COEF_W.
REQ-004 Port clk, input, 1: single clock; all state on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port in_valid, input, 1: coefficient present.
REQ-007 Port in_ready, output, 1: block accepts coefficient this cycle.
REQ-008 Port in_coef, input, COEF_W: signed coefficient in zigzag order, index 0 = DC.
REQ-009 Port in_last, input, 1: marks index BLK_LEN-1; any mismatch with internal count is a protocol error.
REQ-010 Port out_valid, output, 1: symbol present.
REQ-011 Port out_ready, input, 1: consumer accepts symbol.
REQ-012 Port out_run, output, 4: zero run preceding the symbol, 0..15.
REQ-013 Port out_size, output, SIZE_W: category, meaning the bit length of |coef|.
REQ-014 Port out_amp, output, COEF_W: JPEG amplitude bits, LSB-aligned.
REQ-015 Port out_eob, output, 1: symbol is end-of-block (run=0, size=0).
REQ-016 Port err_len, output, 1: sticky; set when in_last disagrees with index count.

Function
REQ-017 Transfers occur only on valid&&ready; out_* SHALL hold stable while out_valid && !out_ready.
REQ-018 Index 0 (DC) SHALL always emit one symbol with run=0, including when the coefficient is zero (size=0, amp=0).
REQ-019 AC zero SHALL increment an internal run counter (width clog2(BLK_LEN)) and emit nothing.
REQ-020 AC nonzero with run R SHALL emit floor(R/16) ZRL symbols (run=15, size=0, amp=0), then one symbol (run=R mod 16, size, amp), then clear run.
REQ-021 amp = coef when coef>0; otherwise (coef-1) masked to size bits.
REQ-022 Most-negative coef SHALL give size=COEF_W with no overflow.
REQ-023 Last AC zero (run>0 after accept) SHALL emit exactly one EOB and discard pending ZRLs.
REQ-024 Last AC nonzero SHALL emit its symbol, with no EOB.
REQ-025 FSM states:
- COLLECT: in_ready = output slot free.
- EMIT_ZRL: in_ready=0; one ZRL per out handshake; decrement ZRL count; leave when count reaches 0.
- EMIT_SYM: in_ready=0; present the held symbol; return to COLLECT on handshake.
- EMIT_EOB: in_ready=0; return to COLLECT on handshake.
REQ-026 Output stage is a single register slot. A new symbol may load in the same cycle the old one is consumed: one symbol per cycle at full throughput.
REQ-027 Latency is 1 cycle from input accept to out_valid for a direct symbol.
REQ-028 Index counter SHALL wrap to 0 after BLK_LEN-1; run SHALL clear at block boundary; the next block starts in the cycle after the final symbol is consumed.
REQ-029 in_last mismatch SHALL set err_len; the block SHALL be ended by the internal count, not by in_last.

Reset
REQ-030 rst SHALL force: state=COLLECT; index=0; run=0; out_valid=0; out_run/out_size/out_amp/out_eob=0; err_len=0; in_ready=0 while rst is high, then 1.
REQ-031 Reset mid-block or mid-ZRL burst SHALL abandon the block without emitting further symbols.

Structure
REQ-032 Package jpeg_rle_pkg SHALL hold the state enum, ZRL/EOB constants (run 15 / size 0) and the symbol struct.
REQ-033 Sub-module jpeg_size_cat SHALL be combinational, producing size and amp from coef.

Verification
REQ-034 DC=-5, then 63 zeros -> (0,3,2) then EOB; 2 symbols total.
REQ-035 DC=1, 40 zeros, AC=+7, 22 zeros -> (0,1,1), ZRL, ZRL, (8,3,7), EOB; in_ready low during the ZRLs.
REQ-036 All 64 coefficients=-2048 (COEF_W=12) -> 64 symbols with size=12, amp=0x7FF, no EOB, back-to-back at out_ready=1.
REQ-037 Random out_ready stalls on REQ-035 stream -> identical symbol sequence; outputs stable while stalled.
REQ-038 in_last asserted at index 10 -> err_len=1; block still ends at index 63.
REQ-039 rst asserted during second ZRL of REQ-035 -> out_valid=0 next cycle; next block encodes correctly.
